// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/disarm control and match counting
module seq_detect_ctrl #(
   parameter  int MAXLEN = 8,
   parameter  int CNTW   = 8,
   localparam int LW     = $clog2(MAXLEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pat,
   input  logic [LW-1:0]     cfg_len,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic              cfg_overlap,
   input  logic              start,
   input  logic              abort,
   input  logic              din,
   input  logic              din_valid,
   output logic              flag,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNTW-1:0]   match_cnt
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;
   state_t            st_q, st_d;
   logic [MAXLEN-1:0] pat_q, pat_d, sr_q, sr_d, sr_sh, mask;
   logic [LW-1:0]     len_q, len_d, fill_q, fill_d, fill_inc;
   logic [CNTW-1:0]   tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
   logic              ovl_q, ovl_d, flag_q, flag_d, err_q, err_d, hit, len_ok;
   assign sr_sh     = {sr_q[MAXLEN-2:0], din};
   assign fill_inc  = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
   assign mask      = ~({MAXLEN{1'b1}} << len_q);
   assign hit       = din_valid && (fill_inc == len_q) && (((sr_sh ^ pat_q) & mask) == '0);
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign len_ok    = (len_q >= LW'(2)) && (len_q <= LW'(MAXLEN));
   assign flag      = flag_q;
   assign err       = err_q;
   assign busy      = (st_q == ARMED);
   assign done      = (st_q == DONE);
   assign match_cnt = cnt_q;
   // next-state: config latch, arming, bit shifting, matching and counting
   always_comb begin
      st_d   = st_q;
      pat_d  = pat_q;
      len_d  = len_q;
      tgt_d  = tgt_q;
      ovl_d  = ovl_q;
      sr_d   = sr_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      flag_d = 1'b0;
      err_d  = 1'b0;
      case (st_q)
         ARMED: begin
            if (abort) st_d = IDLE;
            else if (din_valid) begin
               sr_d   = sr_sh;
               fill_d = fill_inc;
               if (hit) begin
                  flag_d = 1'b1;
                  cnt_d  = cnt_inc;
                  fill_d = ovl_q ? fill_inc : '0;
                  st_d   = (tgt_q != '0 && cnt_inc == tgt_q) ? DONE : ARMED;
               end
            end
         end
         DONE: begin
            if (abort) st_d = IDLE;
            else if (start) begin
               st_d   = ARMED;
               sr_d   = '0;
               fill_d = '0;
               cnt_d  = '0;
            end
         end
         default: begin
            st_d = IDLE;
            if (cfg_we) begin
               pat_d = cfg_pat;
               len_d = cfg_len;
               tgt_d = cfg_target;
               ovl_d = cfg_overlap;
            end else if (start && !abort) begin
               st_d   = len_ok ? ARMED : IDLE;
               err_d  = !len_ok;
               sr_d   = len_ok ? '0 : sr_q;
               fill_d = len_ok ? '0 : fill_q;
               cnt_d  = len_ok ? '0 : cnt_q;
            end
         end
      endcase
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         pat_q  <= '0;
         len_q  <= '0;
         tgt_q  <= '0;
         ovl_q  <= 1'b0;
         sr_q   <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         flag_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         tgt_q  <= tgt_d;
         ovl_q  <= ovl_d;
         sr_q   <= sr_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed and randomized checks of seq_detect_ctrl against a history-based model
module tb_seq_detect_ctrl;
   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_overlap, start, abort, din, din_valid;
   logic [7:0] cfg_pat, cfg_target;
   logic [3:0] cfg_len;
   logic       flag, busy, done, err;
   logic [7:0] match_cnt;
   int         total = 0, bad = 0;
   int         m_state = 0, m_len = 0, m_tgt = 0, m_cnt = 0;
   logic [7:0] m_pat = '0;
   logic       m_ovl = 1'b0, m_flag = 1'b0, m_err = 1'b0;
   bit         hist[$];

   seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_target(cfg_target), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
      .din(din), .din_valid(din_valid), .flag(flag), .busy(busy), .done(done), .err(err),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic r, we, st, ab, d, dv);
      bit ok;
      rst = r; cfg_we = we; start = st; abort = ab; din = d; din_valid = dv;
      @(posedge clk);
      m_flag = 1'b0;
      m_err  = 1'b0;
      if (r) begin
         m_state = 0; m_pat = '0; m_len = 0; m_tgt = 0; m_ovl = 1'b0; m_cnt = 0;
         hist.delete();
      end else if (m_state == 0) begin
         if (we) begin
            m_pat = cfg_pat; m_len = int'(cfg_len); m_tgt = int'(cfg_target); m_ovl = cfg_overlap;
         end else if (st && !ab) begin
            if (m_len >= 2 && m_len <= 8) begin
               m_state = 1; m_cnt = 0; hist.delete();
            end else m_err = 1'b1;
         end
      end else if (m_state == 1) begin
         if (ab) m_state = 0;
         else if (dv) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            ok = (hist.size() >= m_len);
            for (int i = 0; i < m_len && ok; i++)
               if (hist[hist.size() - 1 - i] != m_pat[i]) ok = 0;
            if (ok) begin
               m_flag = 1'b1;
               if (m_cnt < 255) m_cnt++;
               if (!m_ovl) hist.delete();
               if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
            end
         end
      end else begin
         if (ab) m_state = 0;
         else if (st) begin
            m_state = 1; m_cnt = 0; hist.delete();
         end
      end
      #1;
   endtask

   task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t, input logic o);
      cfg_pat = p; cfg_len = l; cfg_target = t; cfg_overlap = o;
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_reset;
      cyc(1, 0, 0, 0, 0, 0);
      configure(8'b0110, 4, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, i[0], 1);
      cyc(1, 0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0, 1);
      total++;
      if ({flag, busy, done, err, match_cnt} !== 12'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=000", {flag, busy, done, err, match_cnt});
      end
      cyc(0, 0, 1, 0, 0, 0);
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_cfg_cleared err=%b busy=%b want err=1 busy=0", err, busy);
      end
   endtask

   task automatic run_0110(input logic o);
      bit b[7] = '{0, 1, 1, 0, 1, 1, 0};
      logic exp;
      cyc(1, 0, 0, 0, 0, 0);
      configure(8'b0110, 4, 0, o);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL arm_busy ovl=%b got=%b want=1", o, busy);
      end
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 0, 0, b[i], 1);
         exp = (i == 3) || (o && i == 6);
         total++;
         if (flag !== exp) begin
            bad++;
            $display("FAIL flag_0110 ovl=%b bit=%0d got=%b want=%b", o, i + 1, flag, exp);
         end
      end
      total++;
      if (match_cnt !== (o ? 8'd2 : 8'd1) || busy !== 1'b1) begin
         bad++;
         $display("FAIL cnt_0110 ovl=%b cnt=%0d busy=%b want cnt=%0d busy=1", o, match_cnt, busy, o ? 2 : 1);
      end
   endtask

   task automatic test_overlap;
      run_0110(1);
   endtask

   task automatic test_nonoverlap;
      run_0110(0);
   endtask

   task automatic test_target;
      logic exp;
      cyc(1, 0, 0, 0, 0, 0);
      configure(8'b11, 2, 3, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 1, 1);
         exp = (i >= 1 && i <= 3);
         total++;
         if (flag !== exp) begin
            bad++;
            $display("FAIL flag_target bit=%0d got=%b want=%b", i + 1, flag, exp);
         end
         if (i == 3) begin
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd3) begin
               bad++;
               $display("FAIL done_target done=%b busy=%b cnt=%0d want 1 0 3", done, busy, match_cnt);
            end
         end
      end
      total++;
      if (done !== 1'b1 || match_cnt !== 8'd3) begin
         bad++;
         $display("FAIL done_hold done=%b cnt=%0d want 1 3", done, match_cnt);
      end
      cyc(0, 0, 1, 0, 0, 0);
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || match_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rearm busy=%b done=%b cnt=%0d want 1 0 0", busy, done, match_cnt);
      end
   endtask

   task automatic test_err;
      cyc(1, 0, 0, 0, 0, 0);
      configure(8'b1, 1, 0, 1);
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL err_pulse err=%b busy=%b want 1 0", err, busy);
      end
      cfg_len = 4;
      cyc(0, 1, 1, 0, 0, 0);
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL err_once_we_start err=%b busy=%b want 0 0", err, busy);
      end
      cyc(0, 0, 1, 0, 0, 0);
      total++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL cfg_taken err=%b busy=%b want 0 1", err, busy);
      end
   endtask

   task automatic test_abort_gap;
      bit b[4] = '{0, 1, 1, 0};
      cyc(1, 0, 0, 0, 0, 0);
      configure(8'b0110, 4, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, b[i], 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 1, 1, 0, 1);
      total++;
      if (flag !== 1'b0 || match_cnt !== 8'd1 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_match flag=%b cnt=%0d busy=%b want 0 1 0", flag, match_cnt, busy);
      end
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      total++;
      if (flag !== 1'b1 || match_cnt !== 8'd1) begin
         bad++;
         $display("FAIL gap_match flag=%b cnt=%0d want 1 1", flag, match_cnt);
      end
   endtask

   task automatic test_random;
      cyc(1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 4000; n++) begin
         cfg_pat     = 8'($urandom);
         cfg_len     = 4'($urandom_range(1, 5));
         cfg_target  = 8'($urandom_range(0, 4));
         cfg_overlap = 1'($urandom);
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 3) != 0));
         total++;
         if ({flag, busy, done, err, match_cnt} !== {m_flag, m_state == 1, m_state == 2, m_err, 8'(m_cnt)}) begin
            bad++;
            $display("FAIL random n=%0d got f%b b%b d%b e%b c%0d want f%b b%b d%b e%b c%0d", n,
                     flag, busy, done, err, match_cnt, m_flag, m_state == 1, m_state == 2, m_err, m_cnt);
         end
      end
   endtask

   initial begin
      cfg_pat = '0; cfg_len = '0; cfg_target = '0; cfg_overlap = 1'b0;
      test_reset;
      test_overlap;
      test_nonoverlap;
      test_target;
      test_err;
      test_abort_gap;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial pattern-detection controller. Holds a software-loaded pattern (2..MAXLEN bits), arms and disarms detection on command, scans a qualified serial bit stream, pulses a flag per match, counts matches and stops at a programmed target count. It sits between the configuration/control side and the serial data path, and generalises the team's fixed-pattern detectors into one sequenced, reusable resource.

## Interface
- MAXLEN, 8, maximum pattern length in bits (≥2)
- CNTW, 8, width of match counter and target
- clk  in  1  clock; all flops update on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  configuration write strobe (honoured in IDLE only)
- cfg_pat  in  MAXLEN  pattern; bit len-1 is the first bit received, bit 0 the last
- cfg_len  in  $clog2(MAXLEN+1)  pattern length; valid range 2..MAXLEN
- cfg_target  in  CNTW  matches to DONE; 0 = unlimited
- cfg_overlap  in  1  1 = overlapping matches allowed
- start  in  1  arm (from IDLE) / re-arm (from DONE)
- abort  in  1  disarm; return to IDLE
- din  in  1  serial data bit
- din_valid  in  1  din qualifier; bit consumed when high
- flag  out  1  one-cycle pulse per match
- busy  out  1  high in ARMED
- done  out  1  high in DONE
- err  out  1  one-cycle pulse: start rejected due to invalid cfg_len
- match_cnt  out  CNTW  matches since last arm

## Operation
- States: IDLE, ARMED, DONE (one-hot or binary; unused encodings decode to IDLE).
- Reset: state=IDLE; config regs, shift reg, fill count, match_cnt=0; flag, busy, done, err=0.
- IDLE: cfg_we latches pat/len/target/overlap. start with latched len in 2..MAXLEN → ARMED, shift reg, fill and match_cnt cleared. start with invalid len → err pulse, stay IDLE.
- cfg_we and start in the same IDLE cycle: config written, start ignored, no err.
- ARMED, per din_valid cycle: sr ← {sr[MAXLEN-2:0], din}; fill ← min(fill+1, len). Match when updated fill == len and sr[len-1:0] == pat[len-1:0].
- On match: flag=1 next cycle, match_cnt+1 (saturates at all-ones when target=0); if overlap=0, fill ← 0 (shift reg content kept, but not compared until refilled).
- Match bringing match_cnt to target (target≠0) → DONE; further din ignored.
- din_valid low: no shift, no match, state held.
- DONE: done=1, match_cnt held. start → ARMED with same config (counters/shift reg cleared). abort → IDLE.
- abort in ARMED or DONE → IDLE next cycle; match_cnt retained; a match in the same cycle is discarded (no flag, no count).
- abort and start together: abort wins.
- cfg_we outside IDLE ignored.

## Timing
- Bit-to-flag latency: 1 cycle (flag high the cycle after the sampling edge of the completing bit).
- match_cnt updates on the same edge flag rises; done/busy change on that same edge for the final match.
- start/abort take effect on the next edge; busy rises the cycle after an accepted start.
- One bit per cycle maximum; back-to-back din_valid fully supported, consecutive flags possible with overlap=1 and patterns such as 11.
- rst mid-operation: all outputs return to reset values next edge, config lost.

## Test plan
- Reset: rst high 2 cycles during ARMED with din toggling → all outputs 0, state IDLE, config cleared.
- pat=0110, len=4, overlap=1, target=0; stream 0,1,1,0,1,1,0 → flag after bits 4 and 7, match_cnt=2, busy stays 1.
- Same with overlap=0 → single flag after bit 4, match_cnt=1.
- pat=11, len=2, target=3, overlap=1; stream 1,1,1,1,1 → flags after bits 2,3,4; done=1, busy=0 after bit 4; bit 5 ignored; start → ARMED, match_cnt=0.
- len=1 then start → err pulse 1 cycle, stays IDLE; cfg_we+start same cycle → config taken, no arm, no err.
- Completing bit with abort same cycle → no flag, match_cnt unchanged, IDLE; din_valid gaps mid-pattern (0,gap,1,1,gap,0) → match still detected.
